cache_mem_wbuf: RTL and testbench

- Write buffer and memory-side controller between the L1 data cache's memory port and the slow block memory.
- Posts 128-bit dirty-block writebacks into a small FIFO so the cache's WRITE state completes in one cycle.
- Drains the FIFO to memory when the cache is idle.
- Serves cache block reads either by forwarding from a matching buffered entry or by a bypass read to memory.

---
 rtl/cache_mem_wbuf_if.sv | 31 +++
 rtl/cache_mem_wbuf.sv | 185 ++++++++++++++++++
 tb/tb_cache_mem_wbuf.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_wbuf_if.sv
// Cache memory-port and block-memory bus bundle for the writeback buffer.
// slave: the buffer/controller side; master: the cache plus memory environment.
interface cache_mem_wbuf_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  logic         dram_read;
  logic         dram_write;
  logic [27:0]  dram_addr;
  logic [127:0] dram_wdata;
  logic [127:0] dram_rdata;
  logic         dram_ready;

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    output dram_read, dram_write, dram_addr, dram_wdata,
    input  dram_rdata, dram_ready
  );

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    input  dram_read, dram_write, dram_addr, dram_wdata,
    output dram_rdata, dram_ready
  );
endinterface

// File: rtl/cache_mem_wbuf.sv
// Write buffer between the L1 data cache memory port and slow block memory.
// Dirty-block writebacks are posted into a small FIFO and acknowledged at once;
// the FIFO drains whenever the cache is idle. Reads are forwarded from a
// matching buffered entry or bypassed to memory.
//
// state  | meaning
// IDLE   | accept a cache request, or start a drain when nothing is pending
// RD_MEM | bypass block read in flight to memory
// DRAIN  | head entry being written to memory
// RESP   | one-cycle mem_ready pulse; cache requests ignored
module cache_mem_wbuf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             proc_reset_n,
  cache_mem_wbuf_if.slave  bus,
  output logic [PTR_W:0]   wbuf_count
);

  typedef enum logic [1:0] {IDLE, RD_MEM, DRAIN, RESP} state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0] ent_valid;
  logic [27:0]      ent_addr [DEPTH];
  logic [127:0]     ent_data [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic             full;

  logic do_coal, do_enq, do_fwd, do_pop, do_rd_load;

  assign wbuf_count = count;
  assign full       = (count == (PTR_W+1)'(DEPTH));

  // Address match against every valid entry; at most one can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == bus.mem_addr)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and datapath strobes; writes win over reads in IDLE.
  always_comb begin
    state_nxt  = state;
    do_coal    = 1'b0;
    do_enq     = 1'b0;
    do_fwd     = 1'b0;
    do_pop     = 1'b0;
    do_rd_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_write) begin
          if (hit) begin
            do_coal   = 1'b1;
            state_nxt = RESP;
          end else if (!full) begin
            do_enq    = 1'b1;
            state_nxt = RESP;
          end else begin
            // Buffer full: free the head slot, then re-evaluate the write.
            state_nxt = DRAIN;
          end
        end else if (bus.mem_read) begin
          if (hit) begin
            do_fwd    = 1'b1;
            state_nxt = RESP;
          end else begin
            // No buffered copy of this block, so memory is current for it.
            state_nxt = RD_MEM;
          end
        end else if (count != '0) begin
          state_nxt = DRAIN;
        end
      end
      RD_MEM: begin
        if (bus.dram_ready) begin
          do_rd_load = 1'b1;
          state_nxt  = RESP;
        end
      end
      DRAIN: begin
        if (bus.dram_ready) begin
          do_pop    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory-side request; decoded from state so reset drops it immediately.
  always_comb begin
    bus.dram_read  = 1'b0;
    bus.dram_write = 1'b0;
    bus.dram_addr  = '0;
    bus.dram_wdata = '0;
    case (state)
      RD_MEM: begin
        bus.dram_read = ~bus.dram_ready;
        bus.dram_addr = bus.mem_addr;
      end
      DRAIN: begin
        bus.dram_write = ~bus.dram_ready;
        bus.dram_addr  = ent_addr[head];
        bus.dram_wdata = ent_data[head];
      end
      default: begin
      end
    endcase
  end

  // Buffer entries, circular pointers and occupancy count.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_coal) begin
        ent_data[hit_idx] <= bus.mem_wdata;
      end
      if (do_enq) begin
        ent_valid[tail] <= 1'b1;
        ent_addr[tail]  <= bus.mem_addr;
        ent_data[tail]  <= bus.mem_wdata;
        tail            <= tail + PTR_W'(1);
      end
      if (do_pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      // Enqueue and pop happen in different states, never together.
      if (do_enq) begin
        count <= count + (PTR_W+1)'(1);
      end else if (do_pop) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // Registered cache response: mem_ready is high exactly while in RESP.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ready <= (state_nxt == RESP);
      if (do_fwd) begin
        bus.mem_rdata <= ent_data[hit_idx];
      end else if (do_rd_load) begin
        bus.mem_rdata <= bus.dram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_wbuf.sv
// Self-checking bench for cache_mem_wbuf: directed scenarios plus a random
// phase, checked against a queue-based buffer model and a memory model.
module tb_cache_mem_wbuf;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] wbuf_count;

  cache_mem_wbuf_if bus ();

  cache_mem_wbuf #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk          (clk),
    .proc_reset_n (rst_n),
    .bus          (bus.slave),
    .wbuf_count   (wbuf_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [27:0]  a;
    logic [127:0] d;
  } ent_t;

  ent_t         wq[$];
  logic [127:0] mem_model [logic [27:0]];
  int           rd_cnt    = 0;
  int           wr_cnt    = 0;
  bit           mem_hold  = 1'b0;
  int           max_delay = 1;
  bit           resp_busy = 1'b0;

  function automatic logic [127:0] mem_val(input logic [27:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {4{a, 4'hc}};
  endfunction

  // Memory responder: random latency, checks drains against the model FIFO head.
  int           dly;
  bit           cur_wr;
  logic [27:0]  cur_a;
  logic [127:0] cur_d;
  always @(negedge clk) begin
    bus.dram_ready = 1'b0;
    if (!rst_n) begin
      resp_busy = 1'b0;
    end else if (resp_busy) begin
      if (!mem_hold) begin
        if (dly > 1) begin
          dly--;
        end else begin
          resp_busy      = 1'b0;
          bus.dram_ready = 1'b1;
          if (cur_wr) begin
            wr_cnt++;
            if (wq.size() == 0) begin
              chk("drain_with_empty_model", 128'(wq.size()), 128'(1));
            end else begin
              chk("drain_addr", 128'(cur_a), 128'(wq[0].a));
              chk("drain_data", cur_d, wq[0].d);
              void'(wq.pop_front());
            end
            mem_model[cur_a] = cur_d;
          end else begin
            rd_cnt++;
            chk("rd_addr", 128'(cur_a), 128'(bus.mem_addr));
            bus.dram_rdata = mem_val(cur_a);
          end
        end
      end
    end else if (bus.dram_write || bus.dram_read) begin
      resp_busy = 1'b1;
      cur_wr    = bus.dram_write;
      cur_a     = bus.dram_addr;
      cur_d     = bus.dram_wdata;
      dly       = $urandom_range(max_delay, 1);
    end
  end

  // mem_ready must never be high on two consecutive cycles.
  bit prev_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst_n) chk("ready_pulse_width", 128'(bus.mem_ready & prev_ready), 128'(0));
    prev_ready = bus.mem_ready;
  end

  // Issue one cache request, wait for mem_ready, then check against the model.
  task automatic cache_op(input bit wr, input logic [27:0] a, input logic [127:0] d, input int exp_lat);
    int n = 0;
    int rd0 = rd_cnt;
    int idx = -1;
    logic [127:0] exp_d;
    bus.mem_write = wr;
    bus.mem_read  = ~wr;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (bus.mem_ready) break;
    end
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    if (!bus.mem_ready) begin
      chk("ack_timeout", 128'(bus.mem_ready), 128'(1));
      return;
    end
    if (exp_lat > 0) chk("ack_latency", 128'(n), 128'(exp_lat));
    foreach (wq[i]) if (wq[i].a == a) idx = i;
    if (wr) begin
      if (idx >= 0) wq[idx].d = d;
      else if (wq.size() < DEPTH) wq.push_back('{a, d});
      else chk("accept_when_full", 128'(wq.size()), 128'(DEPTH - 1));
    end else begin
      exp_d = (idx >= 0) ? wq[idx].d : mem_val(a);
      chk("rd_data", bus.mem_rdata, exp_d);
      chk("rd_mem_access", 128'(rd_cnt - rd0), 128'((idx >= 0) ? 0 : 1));
    end
    chk("wbuf_count", 128'(wbuf_count), 128'(wq.size()));
  endtask

  task automatic wait_drained();
    int n = 0;
    while (n < 1000 && (wbuf_count != 0 || resp_busy || bus.dram_write)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drained_count", 128'(wbuf_count), 128'(0));
    chk("drained_model", 128'(wq.size()), 128'(0));
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(posedge clk);
    wq.delete();
    mem_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    logic [127:0] dx;
    rst_n          = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.dram_ready = 1'b0;
    bus.dram_rdata = '0;

    // Reset values
    repeat (2) @(posedge clk); #1;
    chk("rst_count",      128'(wbuf_count),     128'(0));
    chk("rst_mem_ready",  128'(bus.mem_ready),  128'(0));
    chk("rst_mem_rdata",  bus.mem_rdata,        128'(0));
    chk("rst_dram_read",  128'(bus.dram_read),  128'(0));
    chk("rst_dram_write", 128'(bus.dram_write), 128'(0));
    chk("rst_dram_addr",  128'(bus.dram_addr),  128'(0));
    chk("rst_dram_wdata", bus.dram_wdata,       128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single posted write with stalled memory, then its drain
    mem_hold = 1'b1;
    cache_op(1'b1, 28'h0000010, {16{8'ha5}}, 1);
    repeat (2) @(posedge clk); #1;
    chk("drain_start_write", 128'(bus.dram_write), 128'(1));
    chk("drain_start_addr",  128'(bus.dram_addr),  128'(28'h0000010));
    chk("drain_start_data",  bus.dram_wdata,       {16{8'ha5}});
    mem_hold = 1'b0;
    wait_drained();

    // Coalescing two writes to the same block
    w0 = wr_cnt;
    cache_op(1'b1, 28'h10, {4{32'h1111_0000}}, 0);
    cache_op(1'b1, 28'h10, {4{32'h2222_ffff}}, 0);
    wait_drained();
    chk("coalesce_writes", 128'(wr_cnt - w0), 128'(1));
    chk("coalesce_mem",    mem_val(28'h10),   {4{32'h2222_ffff}});

    // Forward read from buffer, then a bypass read of another block
    apply_reset();
    max_delay = 3;
    cache_op(1'b1, 28'h20, {4{32'hdead_beef}}, 1);
    cache_op(1'b0, 28'h20, '0, 2);
    cache_op(1'b0, 28'h30, '0, 0);
    wait_drained();

    // Reset in the middle of a drain with three entries buffered
    apply_reset();
    mem_hold = 1'b1;
    cache_op(1'b1, 28'h100, {4{32'h0000_0100}}, 0);
    cache_op(1'b1, 28'h200, {4{32'h0000_0200}}, 0);
    cache_op(1'b1, 28'h300, {4{32'h0000_0300}}, 0);
    repeat (3) @(posedge clk); #1;
    chk("pre_rst_dram_write", 128'(bus.dram_write), 128'(1));
    chk("pre_rst_count",      128'(wbuf_count),     128'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dram_write", 128'(bus.dram_write), 128'(0));
    chk("mid_rst_count",      128'(wbuf_count),     128'(0));
    chk("mid_rst_mem_ready",  128'(bus.mem_ready),  128'(0));
    wq.delete();
    mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cache_op(1'b0, 28'h100, '0, 0);

    // Full buffer: fifth write waits for the head to drain
    apply_reset();
    mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) cache_op(1'b1, 28'h400 + 28'(i), {4{32'(i) + 32'h4000}}, 0);
    chk("full_count", 128'(wbuf_count), 128'(4));
    fork
      cache_op(1'b1, 28'h500, {4{32'h5000_5000}}, 0);
      begin
        repeat (10) @(posedge clk); #2;
        chk("full_no_ready",    128'(bus.mem_ready),  128'(0));
        chk("full_drain_write", 128'(bus.dram_write), 128'(1));
        chk("full_drain_addr",  128'(bus.dram_addr),  128'(28'h400));
        mem_hold = 1'b0;
      end
    join
    wait_drained();

    // Eight back-to-back writes with random memory latency
    apply_reset();
    max_delay = 10;
    w0 = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      dx = {$urandom, $urandom, $urandom, $urandom};
      cache_op(1'b1, 28'h1000 + 28'(i * 7), dx, 0);
    end
    wait_drained();
    chk("b2b_writes", 128'(wr_cnt - w0), 128'(8));

    // Random mix over a small address pool
    max_delay = 6;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
      dx = {$urandom, $urandom, $urandom, $urandom};
      cache_op(1'($urandom_range(1, 0)), 28'h2000 + 28'($urandom_range(5, 0)), dx, 0);
    end
    wait_drained();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
